mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: an instruction-fetch port and a data
// load/store port share one fixed-latency memory. The FSM owns the port for
// one transaction at a time. Simultaneous requests are resolved round-robin.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int MEM_LAT = 2    // memory read latency, 1..15
) (
   input  logic              clk,
   input  logic              reset,
   // instruction-fetch port
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   // data load/store port
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ack_o,
   // shared memory port
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_we_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_IF   = 2'b01;
   localparam logic [1:0] GRANT_D    = 2'b10;

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic                owner_d_q;      // 1 = current transaction belongs to the data port
   logic                last_d_q;       // 1 = data port was granted most recently
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic                mem_we_q;
   logic [1:0]          grant_q;
   logic                if_ack_q;
   logic                d_ack_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   d_rdata_q;
   logic                win_d;

   // Winner selection: data wins when alone, or on a conflict if fetch was served last.
   always_comb begin
      win_d = d_req_i & (~if_req_i | ~last_d_q);
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         owner_d_q  <= 1'b0;
         last_d_q   <= 1'b0;   // fetch counts as last served, so data wins the first conflict
         // NOTE: the datapath registers are reset too because the address,
         // write-data and read-data outputs must read zero straight out of reset.
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         mem_we_q   <= 1'b0;
         grant_q    <= GRANT_NONE;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         // NOTE: pulse outputs default low every cycle and are only set for the
         // single cycle that needs them; the later non-blocking writes win.
         mem_we_q <= 1'b0;
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (if_req_i || d_req_i) begin
                  owner_d_q <= win_d;
                  last_d_q  <= win_d;
                  cnt_q     <= 4'(MEM_LAT - 1);
                  state_q   <= ACCESS;
                  if (win_d) begin
                     addr_q   <= d_addr_i;
                     wdata_q  <= d_wdata_i;
                     we_q     <= d_we_i;
                     mem_we_q <= d_we_i;
                     grant_q  <= GRANT_D;
                  end else begin
                     addr_q   <= if_addr_i;
                     we_q     <= 1'b0;
                     grant_q  <= GRANT_IF;
                  end
               end
            end
            ACCESS: begin
               if (cnt_q == 4'd0) begin
                  state_q <= DONE;
                  if (owner_d_q) begin
                     d_ack_q <= 1'b1;
                     if (!we_q) d_rdata_q <= mem_rdata_i;
                  end else begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mem_rdata_i;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               grant_q <= GRANT_NONE;
               state_q <= IDLE;
            end
            default: begin
               grant_q <= GRANT_NONE;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_we_o    = mem_we_q;
   assign grant_o     = grant_q;
   assign if_ack_o    = if_ack_q;
   assign d_ack_o     = d_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;

endmodule
